branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch prediction unit for the five-stage RISC-V pipeline.
- Provides a taken/target prediction to IF every cycle.
- Resolves control-transfer instructions arriving from EX and generates the front-end redirect.
- Updates a direct-mapped BTB with 2-bit saturating counters.
- Emits the per-instruction control/misprediction pulses consumed by the pipeline debug outputs and the ISA-test performance scoreboard.

## Interface
- BHT_ENTRIES, 64, number of BTB/counter entries; power of two, ≥4
- IDX_W, $clog2(BHT_ENTRIES), index width (derived, not overridden)
- i_clk  in  1  clock, rising-edge
- i_reset  in  1  reset; asynchronous, active-low
- i_if_pc  in  32  fetch PC to predict
- o_pred_taken  out  1  prediction for i_if_pc
- o_pred_target  out  32  predicted next PC: BTB target if o_pred_taken, else i_if_pc+4
- i_ex_vld  in  1  EX holds a real (unsquashed) instruction
- i_ex_stall  in  1  EX held this cycle; no resolution is committed
- i_ex_pc  in  32  PC of EX instruction
- i_ex_is_br  in  1  conditional branch
- i_ex_is_jmp  in  1  JAL/JALR
- i_ex_taken  in  1  actual outcome (ignored for jumps, treated as 1)
- i_ex_target  in  32  actual target
- i_ex_pred_taken  in  1  prediction carried down from IF
- i_ex_pred_target  in  32  predicted target carried down from IF
- o_redirect  out  1  flush IF/ID and refetch
- o_redirect_pc  out  32  refetch address
- o_ctrl  out  1  registered pulse: one control instruction resolved
- o_mispred  out  1  registered pulse: that instruction mispredicted

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Each entry holds valid, tag, target[31:0], ctr[1:0].
- Lookup is combinational on stored state: hit = valid & tag match; o_pred_taken = hit & ctr[1].
- Resolve = i_ex_vld & ~i_ex_stall & (i_ex_is_br | i_ex_is_jmp). The actual-taken signal is i_ex_taken for branches and 1 for jumps.
- Mispredict = resolve & (pred_taken ≠ actual_taken | (actual_taken & pred_target ≠ i_ex_target)).
- o_redirect = mispredict (combinational).
- o_redirect_pc = actual_taken ? i_ex_target : i_ex_pc+4. The +4 wraps modulo 2^32.
- Counter update on resolve:
  - Branch: taken → saturating increment; not taken → saturating decrement.
  - Jump: ctr ← 2'b11.
  - Counter states: SNT=00, WNT=01, WT=10, ST=11.
- BTB update on resolve:
  - Actual taken: write valid=1, tag, target. If the entry is a hit, keep its counter and apply the rule above. If it is a miss, replace the entry and initialise ctr to WT (branch) or ST (jump).
  - Not taken and hit: counter update only.
  - Not taken and miss: no write.
- i_ex_is_br and i_ex_is_jmp both high is illegal; jump wins.
- A lookup and an update to the same index in the same cycle: the lookup sees the pre-update entry. No bypass.

## Timing
- Prediction path: zero latency; o_pred_* are valid in the same cycle as i_if_pc.
- Redirect path: zero latency from the EX inputs.
- Table write lands at the rising edge that ends the resolve cycle and is visible to lookups the next cycle.
- o_ctrl and o_mispred are registered one cycle after resolve and are exactly one cycle wide per resolved instruction.
- A stalled EX instruction produces exactly one resolve, in its first cycle with i_ex_stall=0.
- Reset (asynchronous, mid-operation allowed):
  - All valid bits ← 0 and all ctr ← WNT.
  - o_ctrl=0, o_mispred=0.
  - o_redirect follows its inputs; the pipeline holds i_ex_vld=0 during reset, so o_redirect=0.
  - Release is synchronous to the next rising edge.

## Structure
- Package bp_pkg holds:
  - the ctr_e enum (SNT/WNT/WT/ST);
  - the btb_entry_t struct (valid, tag, target, ctr);
  - functions sat_inc and sat_dec.
- One sub-module, btb_table: entry array with async-reset valid/ctr, one combinational read port, one synchronous write port.
- The top level holds the resolve/mispredict logic, the redirect mux and the output pulse registers.

## Test plan
BHT_ENTRIES=16 for all scenarios.
1. **Reset:** release reset, i_if_pc=0x40 → o_pred_taken=0, o_pred_target=0x44; o_ctrl=o_mispred=0.
2. **First taken branch:** resolve a branch at 0x40, taken to 0x10, pred_taken=0 → o_redirect=1, o_redirect_pc=0x10. Next cycle o_ctrl=1 and o_mispred=1. A following lookup of 0x40 gives taken, target 0x10.
3. **Saturation:** three more taken resolves then one not-taken at 0x40 → counter WT→ST, then ST→WT; the prediction stays taken. A not-taken resolve with pred_taken=1 gives redirect_pc=0x44.
4. **Alias:** after scenario 2, look up 0x80 (same index, different tag) → o_pred_taken=0, target 0x84.
5. **Target change:** JALR at 0x100 installed with target 0x200. Resolve it with actual 0x300, pred 0x200 → mispredict, redirect to 0x300; the entry now predicts 0x300.
6. **Stall:** a branch held in EX with i_ex_stall=1 for 3 cycles, then 0 → a single table update and a single o_ctrl pulse. Assert reset mid-sequence → all predictions return to not-taken.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg: shared types and helpers for the branch predictor.
//   ctr_e       - 2-bit saturating counter states (SNT/WNT/WT/ST)
//   btb_entry_t - one BTB entry (valid, tag, target, ctr)
//   sat_inc     - saturating increment of a counter
//   sat_dec     - saturating decrement of a counter
// The tag field is sized for the smallest legal table (4 entries, 30-2=28
// bits would suffice, 30 covers every size); tags are zero-extended into it
// so one struct type serves any BHT_ENTRIES.
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int ADDR_W    = 32;
    localparam int TAG_MAX_W = 30;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic                  valid;
        logic [TAG_MAX_W-1:0]  tag;
        logic [ADDR_W-1:0]     target;
        ctr_e                  ctr;
    } btb_entry_t;

    function automatic ctr_e sat_inc(input ctr_e c);
        ctr_e r;
        case (c)
            SNT:     r = WNT;
            WNT:     r = WT;
            default: r = ST;
        endcase
        return r;
    endfunction

    function automatic ctr_e sat_dec(input ctr_e c);
        ctr_e r;
        case (c)
            ST:      r = WT;
            WT:      r = WNT;
            default: r = SNT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// ---------------------------------------------------------------------------
// bp_if: signal bundle between the pipeline and the branch predictor.
//   IF side : i_if_pc -> o_pred_taken, o_pred_target
//   EX side : i_ex_* resolution inputs -> o_redirect, o_redirect_pc
//   Debug   : o_ctrl, o_mispred one-cycle pulses
// modport master = pipeline (drives i_*), modport slave = predictor.
// ---------------------------------------------------------------------------
interface bp_if;

    logic [31:0] i_if_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;

    logic        i_ex_vld;
    logic        i_ex_stall;
    logic [31:0] i_ex_pc;
    logic        i_ex_is_br;
    logic        i_ex_is_jmp;
    logic        i_ex_taken;
    logic [31:0] i_ex_target;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_pred_target;

    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_ctrl;
    logic        o_mispred;

    modport master (
        output i_if_pc,
        output i_ex_vld, i_ex_stall, i_ex_pc, i_ex_is_br, i_ex_is_jmp,
        output i_ex_taken, i_ex_target, i_ex_pred_taken, i_ex_pred_target,
        input  o_pred_taken, o_pred_target,
        input  o_redirect, o_redirect_pc, o_ctrl, o_mispred
    );

    modport slave (
        input  i_if_pc,
        input  i_ex_vld, i_ex_stall, i_ex_pc, i_ex_is_br, i_ex_is_jmp,
        input  i_ex_taken, i_ex_target, i_ex_pred_taken, i_ex_pred_target,
        output o_pred_taken, o_pred_target,
        output o_redirect, o_redirect_pc, o_ctrl, o_mispred
    );

endinterface

// File: rtl/branch_predictor_btb_table.sv
// ---------------------------------------------------------------------------
// btb_table: direct-mapped BTB storage with counters.
//   clk, rst_n      - clock, asynchronous active-low reset (valid/ctr only)
//   rd_idx/rd_entry - combinational read port (used by IF lookup)
//   wr_en           - commit one resolved control instruction
//   wr_idx, wr_tag  - entry index and (zero-extended) tag of the instruction
//   wr_target       - actual target
//   wr_taken        - actual outcome (already forced to 1 for jumps)
//   wr_jmp          - instruction was a jump
// The write port decides hit/miss against its own stored entry, so the
// update policy (replace vs. train counter) lives next to the state it
// modifies and the table needs only one external read port.
// Tag/target storage is not reset: it is only meaningful when valid is set.
// ---------------------------------------------------------------------------
module btb_table
    import bp_pkg::*;
#(
    parameter int N_ENTRIES = 64,
    parameter int IDX_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     rd_idx,
    output btb_entry_t           rd_entry,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_MAX_W-1:0] wr_tag,
    input  logic [ADDR_W-1:0]    wr_target,
    input  logic                 wr_taken,
    input  logic                 wr_jmp
);

    logic                 valid_arr  [N_ENTRIES];
    logic [TAG_MAX_W-1:0] tag_arr    [N_ENTRIES];
    logic [ADDR_W-1:0]    target_arr [N_ENTRIES];
    ctr_e                 ctr_arr    [N_ENTRIES];

    genvar gi;
    generate
        for (gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
            logic                 valid_reg;
            logic [TAG_MAX_W-1:0] tag_reg;
            logic [ADDR_W-1:0]    target_reg;
            ctr_e                 ctr_reg;
            logic                 wr_sel;
            logic                 wr_hit;

            assign wr_sel = wr_en && (wr_idx == IDX_W'(gi));
            assign wr_hit = valid_reg && (tag_reg == wr_tag);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    ctr_reg   <= WNT;
                end else if (wr_sel) begin
                    if (wr_taken) begin
                        valid_reg <= 1'b1;
                        // Hit keeps training the existing counter; a miss
                        // installs a fresh entry biased toward taken.
                        if (wr_jmp)
                            ctr_reg <= ST;
                        else if (wr_hit)
                            ctr_reg <= sat_inc(ctr_reg);
                        else
                            ctr_reg <= WT;
                    end else if (wr_hit) begin
                        ctr_reg <= sat_dec(ctr_reg);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (wr_sel && wr_taken) begin
                    tag_reg    <= wr_tag;
                    target_reg <= wr_target;
                end
            end

            assign valid_arr[gi]  = valid_reg;
            assign tag_arr[gi]    = tag_reg;
            assign target_arr[gi] = target_reg;
            assign ctr_arr[gi]    = ctr_reg;
        end
    endgenerate

    always_comb begin
        rd_entry        = '0;
        rd_entry.valid  = valid_arr[rd_idx];
        rd_entry.tag    = tag_arr[rd_idx];
        rd_entry.target = target_arr[rd_idx];
        rd_entry.ctr    = ctr_arr[rd_idx];
    end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor: dynamic branch prediction unit.
//   i_clk   - clock, rising edge
//   i_reset - asynchronous active-low reset
//   bus     - bp_if.slave: IF lookup, EX resolution, redirect, debug pulses
// IF lookup and EX redirect are purely combinational. A resolved control
// instruction updates the BTB at the end of its resolve cycle; a lookup to
// the same index in that cycle sees the old entry (no bypass).
// o_ctrl / o_mispred are registered one-cycle pulses per resolve.
// ---------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int BHT_ENTRIES = 64
) (
    input logic i_clk,
    input logic i_reset,
    bp_if.slave bus
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // ---------------- IF lookup ----------------
    logic [IDX_W-1:0]     if_idx;
    logic [TAG_MAX_W-1:0] if_tag;
    btb_entry_t           if_entry;
    logic                 if_hit;
    logic                 if_taken;

    assign if_idx   = bus.i_if_pc[IDX_W+1:2];
    assign if_tag   = TAG_MAX_W'(bus.i_if_pc[31:IDX_W+2]);
    assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);
    assign if_taken = if_hit && (if_entry.ctr == WT || if_entry.ctr == ST);

    assign bus.o_pred_taken  = if_taken;
    assign bus.o_pred_target = if_taken ? if_entry.target : (bus.i_if_pc + 32'd4);

    // ---------------- EX resolution ----------------
    logic             actual_taken;
    logic             resolve;
    logic             mispredict;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_MAX_W-1:0] ex_tag;

    // A jump is always taken; if both type flags are set the jump wins.
    assign actual_taken = bus.i_ex_is_jmp || (bus.i_ex_is_br && bus.i_ex_taken);
    assign resolve      = bus.i_ex_vld && !bus.i_ex_stall
                          && (bus.i_ex_is_br || bus.i_ex_is_jmp);
    assign mispredict   = resolve
                          && ((bus.i_ex_pred_taken != actual_taken)
                              || (actual_taken && (bus.i_ex_pred_target != bus.i_ex_target)));

    assign ex_idx = bus.i_ex_pc[IDX_W+1:2];
    assign ex_tag = TAG_MAX_W'(bus.i_ex_pc[31:IDX_W+2]);

    assign bus.o_redirect    = mispredict;
    assign bus.o_redirect_pc = actual_taken ? bus.i_ex_target : (bus.i_ex_pc + 32'd4);

    btb_table #(
        .N_ENTRIES (BHT_ENTRIES),
        .IDX_W     (IDX_W)
    ) u_btb (
        .clk       (i_clk),
        .rst_n     (i_reset),
        .rd_idx    (if_idx),
        .rd_entry  (if_entry),
        .wr_en     (resolve),
        .wr_idx    (ex_idx),
        .wr_tag    (ex_tag),
        .wr_target (bus.i_ex_target),
        .wr_taken  (actual_taken),
        .wr_jmp    (bus.i_ex_is_jmp)
    );

    // ---------------- debug / scoreboard pulses ----------------
    logic ctrl_reg;
    logic mispred_reg;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ctrl_reg    <= 1'b0;
            mispred_reg <= 1'b0;
        end else begin
            ctrl_reg    <= resolve;
            mispred_reg <= mispredict;
        end
    end

    assign bus.o_ctrl    = ctrl_reg;
    assign bus.o_mispred = mispred_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor: directed scenarios followed by random traffic, all
// checked against a behavioural BTB model (16 entries) held in this bench.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int N = 16;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;
    int   n_pulse = 0;

    bp_if bus ();

    branch_predictor #(.BHT_ENTRIES(N)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_valid  [N];
    int unsigned m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];   // 0..3, >=2 means predict taken

    function automatic int midx(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic int unsigned mtag(input logic [31:0] pc);
        return int'(pc / (4 * N));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int  i;
        bit  hit;
        i   = midx(pc);
        hit = m_valid[i] && (m_tag[i] == mtag(pc));
        tk  = hit && (m_ctr[i] >= 2);
        tg  = tk ? m_target[i] : pc + 32'd4;
    endtask

    task automatic model_update(input logic [31:0] pc, input bit jmp, input bit act,
                                input logic [31:0] tgt);
        int i;
        bit hit;
        i   = midx(pc);
        hit = m_valid[i] && (m_tag[i] == mtag(pc));
        if (act) begin
            if (jmp)      m_ctr[i] = 3;
            else if (hit) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            else          m_ctr[i] = 2;
            m_valid[i]  = 1'b1;
            m_tag[i]    = mtag(pc);
            m_target[i] = tgt;
        end else if (hit) begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ex_idle();
        bus.i_ex_vld = 0; bus.i_ex_stall = 0; bus.i_ex_pc = 0;
        bus.i_ex_is_br = 0; bus.i_ex_is_jmp = 0; bus.i_ex_taken = 0;
        bus.i_ex_target = 0; bus.i_ex_pred_taken = 0; bus.i_ex_pred_target = 0;
    endtask

    task automatic ex_drive(input bit stall, input logic [31:0] pc, input bit br, input bit jmp,
                            input bit tk, input logic [31:0] tgt, input bit ptk,
                            input logic [31:0] ptgt);
        bus.i_ex_vld = 1; bus.i_ex_stall = stall; bus.i_ex_pc = pc;
        bus.i_ex_is_br = br; bus.i_ex_is_jmp = jmp; bus.i_ex_taken = tk;
        bus.i_ex_target = tgt; bus.i_ex_pred_taken = ptk; bus.i_ex_pred_target = ptgt;
    endtask

    // One cycle: entered just after a falling edge with inputs applied.
    task automatic tick();
        logic        e_tk;
        logic [31:0] e_tg;
        logic [31:0] e_rpc;
        bit          act, res, mis;
        #1;
        model_predict(bus.i_if_pc, e_tk, e_tg);
        act   = bus.i_ex_is_jmp || (bus.i_ex_is_br && bus.i_ex_taken);
        res   = bus.i_ex_vld && !bus.i_ex_stall && (bus.i_ex_is_br || bus.i_ex_is_jmp);
        mis   = res && ((bus.i_ex_pred_taken != act)
                        || (act && bus.i_ex_pred_target != bus.i_ex_target));
        e_rpc = act ? bus.i_ex_target : bus.i_ex_pc + 32'd4;
        chk("pred_taken",  32'(bus.o_pred_taken), 32'(e_tk));
        chk("pred_target", bus.o_pred_target, e_tg);
        chk("redirect",    32'(bus.o_redirect), 32'(mis));
        chk("redirect_pc", bus.o_redirect_pc, e_rpc);
        @(posedge clk);
        if (res) model_update(bus.i_ex_pc, bus.i_ex_is_jmp, act, bus.i_ex_target);
        #1;
        chk("o_ctrl",    32'(bus.o_ctrl), 32'(res));
        chk("o_mispred", 32'(bus.o_mispred), 32'(mis));
        if (bus.o_ctrl === 1'b1) n_pulse++;
        $display("txn %0d if_pc=%h ex_pc=%h resolve=%0d mispred=%0d redirect_pc=%h",
                 n_txn, bus.i_if_pc, bus.i_ex_pc, res, mis, e_rpc);
        n_txn++;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 99) < 3) return 32'hFFFF_FFFC;
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    initial begin
        logic [31:0] pc, tgt, ptgt;
        logic        ptk;
        bit          br, jmp;

        rst_n = 1'b0;
        bus.i_if_pc = 32'h40;
        ex_idle();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ctrl",    32'(bus.o_ctrl), 32'd0);
        chk("rst_mispred", 32'(bus.o_mispred), 32'd0);
        rst_n = 1'b1;

        // 1. reset state lookup
        #1;
        chk("s1_pred_taken",  32'(bus.o_pred_taken), 32'd0);
        chk("s1_pred_target", bus.o_pred_target, 32'h44);
        tick();

        // 2. first taken branch at 0x40 -> 0x10
        ex_drive(0, 32'h40, 1, 0, 1, 32'h10, 0, 32'h44);
        #1;
        chk("s2_redirect",    32'(bus.o_redirect), 32'd1);
        chk("s2_redirect_pc", bus.o_redirect_pc, 32'h10);
        tick();
        chk("s2_ctrl_pulse",    32'(bus.o_ctrl), 32'd1);
        chk("s2_mispred_pulse", 32'(bus.o_mispred), 32'd1);
        ex_idle();
        #1;
        chk("s2_lookup_taken",  32'(bus.o_pred_taken), 32'd1);
        chk("s2_lookup_target", bus.o_pred_target, 32'h10);
        tick();

        // 4. alias: same index, different tag
        bus.i_if_pc = 32'h80;
        #1;
        chk("s4_alias_taken",  32'(bus.o_pred_taken), 32'd0);
        chk("s4_alias_target", bus.o_pred_target, 32'h84);
        tick();

        // 3. saturation then one not-taken
        bus.i_if_pc = 32'h40;
        repeat (3) begin
            ex_drive(0, 32'h40, 1, 0, 1, 32'h10, 1, 32'h10);
            tick();
        end
        ex_drive(0, 32'h40, 1, 0, 0, 32'h10, 1, 32'h10);
        #1;
        chk("s3_nt_redirect_pc", bus.o_redirect_pc, 32'h44);
        tick();
        ex_idle();
        #1;
        chk("s3_still_taken", 32'(bus.o_pred_taken), 32'd1);
        tick();

        // 5. JALR target change at 0x100
        bus.i_if_pc = 32'h100;
        ex_drive(0, 32'h100, 0, 1, 1, 32'h200, 0, 32'h104);
        tick();
        ex_drive(0, 32'h100, 0, 1, 1, 32'h300, 1, 32'h200);
        #1;
        chk("s5_redirect",    32'(bus.o_redirect), 32'd1);
        chk("s5_redirect_pc", bus.o_redirect_pc, 32'h300);
        tick();
        ex_idle();
        #1;
        chk("s5_new_target", bus.o_pred_target, 32'h300);
        tick();

        // 6. stalled branch: exactly one resolve
        bus.i_if_pc = 32'h24;
        n_pulse = 0;
        ex_drive(1, 32'h24, 1, 0, 1, 32'h60, 0, 32'h28);
        repeat (3) tick();
        bus.i_ex_stall = 0;
        tick();
        ex_idle();
        tick();
        chk("s6_single_pulse", 32'(n_pulse), 32'd1);
        #1;
        chk("s6_trained", 32'(bus.o_pred_taken), 32'd1);

        // asynchronous reset while a pulse is being held
        ex_drive(0, 32'h1C, 1, 0, 1, 32'h8, 0, 32'h20);
        tick();
        ex_idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_ctrl", 32'(bus.o_ctrl), 32'd0);
        model_reset();
        foreach (m_ctr[i]) begin
            bus.i_if_pc = 32'(i) << 2;
            #0.1;
            chk("rst_pred_nt", 32'(bus.o_pred_taken), 32'd0);
        end
        bus.i_if_pc = 32'h24;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // random traffic against the model
        for (int t = 0; t < 400; t++) begin
            bus.i_if_pc = rand_pc();
            if ($urandom_range(0, 9) < 8) begin
                pc  = rand_pc();
                tgt = 32'($urandom_range(0, 63)) << 2;
                jmp = ($urandom_range(0, 3) == 0);
                br  = !jmp || ($urandom_range(0, 9) == 0);
                model_predict(pc, ptk, ptgt);
                if ($urandom_range(0, 3) == 0) ptk = ~ptk;
                if ($urandom_range(0, 3) == 0) ptgt = 32'($urandom_range(0, 63)) << 2;
                ex_drive($urandom_range(0, 4) == 0, pc, br, jmp, 1'($urandom_range(0, 1)),
                         tgt, ptk, ptgt);
            end else begin
                ex_idle();
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
